// File: rtl/unary_decoder.sv
// Serial unary bitstream to binary ones-count sink with a valid/ready result port.
// Optional bound outputs are enabled with the UNARY_DECODER_BOUNDS_EN macro.
module unary_decoder #(
  parameter int INPUT_WIDTH = 32,
  parameter int COUNT_WIDTH = $clog2(INPUT_WIDTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid,
  input  logic                   y,
  input  logic                   clear,
  output logic [COUNT_WIDTH-1:0] value,
  output logic                   value_valid,
  input  logic                   value_ready,
`ifdef UNARY_DECODER_BOUNDS_EN
  output logic [COUNT_WIDTH-1:0] lower_bound,
  output logic [COUNT_WIDTH-1:0] upper_bound,
`endif
  output logic                   drop
);

  typedef enum logic {COLLECT, DONE} state_t;

  localparam logic [COUNT_WIDTH-1:0] LAST_INDEX = COUNT_WIDTH'(INPUT_WIDTH - 1);

  state_t                 state;
  logic [COUNT_WIDTH-1:0] ones;
  logic [COUNT_WIDTH-1:0] count;
  logic [COUNT_WIDTH-1:0] y_ext;

  assign y_ext = COUNT_WIDTH'(y);

  // The final bit's result goes straight into value so the counters can restart at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= COLLECT;
      ones        <= '0;
      count       <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      drop        <= 1'b0;
    end else if (clear) begin
      state       <= COLLECT;
      ones        <= '0;
      count       <= '0;
      value_valid <= 1'b0;
      drop        <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (valid) begin
            if (count == LAST_INDEX) begin
              value       <= ones + y_ext;
              value_valid <= 1'b1;
              state       <= DONE;
              ones        <= '0;
              count       <= '0;
            end else begin
              ones  <= ones + y_ext;
              count <= count + 1'b1;
            end
          end
        end
        DONE: begin
          if (valid) begin
            drop <= 1'b1;
          end
          if (value_ready) begin
            value_valid <= 1'b0;
            state       <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

`ifdef UNARY_DECODER_BOUNDS_EN
  // ones never exceeds count, so the upper bound stays within INPUT_WIDTH.
  always_comb begin
    lower_bound = ones;
    upper_bound = ones + COUNT_WIDTH'(INPUT_WIDTH) - count;
    if (state == DONE) begin
      lower_bound = value;
      upper_bound = value;
    end
  end
`endif

endmodule

// File: tb/tb_unary_decoder.sv
// Directed scoreboard bench for unary_decoder with INPUT_WIDTH=8.
// Bound checks are compiled in when UNARY_DECODER_BOUNDS_EN is defined.
module tb_unary_decoder;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          valid;
  logic          y;
  logic          clear;
  logic          value_ready;
  logic [CW-1:0] value;
  logic          value_valid;
  logic          drop;
`ifdef UNARY_DECODER_BOUNDS_EN
  logic [CW-1:0] lower_bound;
  logic [CW-1:0] upper_bound;
`endif

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  unary_decoder #(.INPUT_WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .valid       (valid),
    .y           (y),
    .clear       (clear),
    .value       (value),
    .value_valid (value_valid),
    .value_ready (value_ready),
`ifdef UNARY_DECODER_BOUNDS_EN
    .lower_bound (lower_bound),
    .upper_bound (upper_bound),
`endif
    .drop        (drop)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then return 1ns after the sampling edge.
  task automatic apply_stimulus(input logic v, input logic b);
    valid = v;
    y     = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [W-1:0] bits, input int gap);
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) exp_q.push_back($countones(bits));
      apply_stimulus(1'b1, bits[i]);
      if (i != W - 1)
        for (int g = 0; g < gap; g++) apply_stimulus(1'b0, 1'b0);
    end
    check_output("valid_after_last_bit", value_valid, 1);
  endtask

  task automatic pop_check(input string tag);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("[TB] FAIL %s observed=queue_empty expected=entry", tag);
    end else begin
      check_output(tag, value, exp_q.pop_front());
    end
  endtask

  initial begin
    reset       = 1'b0;
    valid       = 1'b0;
    y           = 1'b0;
    clear       = 1'b0;
    value_ready = 1'b0;
    @(posedge clk);
    #1;
    check_output("reset_value", value, 0);
    check_output("reset_value_valid", value_valid, 0);
    check_output("reset_drop", drop, 0);
    reset = 1'b1;
`ifdef UNARY_DECODER_BOUNDS_EN
    check_output("reset_lower", lower_bound, 0);
    check_output("reset_upper", upper_bound, W);
`endif

    $display("[TB] frame 1: continuous, ready high");
    value_ready = 1'b1;
    for (int i = 0; i < W - 1; i++) begin
      apply_stimulus(1'b1, (8'b0100_1101 >> i) & 1'b1);
    end
    check_output("no_valid_before_last", value_valid, 0);
    exp_q.push_back(4);
    apply_stimulus(1'b1, 1'b0);
    check_output("f1_valid", value_valid, 1);
    pop_check("f1_value");
    apply_stimulus(1'b0, 1'b0);
    check_output("f1_handshake_valid", value_valid, 0);
    check_output("f1_value_retained", value, 4);
    check_output("f1_no_drop", drop, 0);

    $display("[TB] frame 2: gapped, ready held low");
    value_ready = 1'b0;
    send_frame(8'b0100_1101, 2);
    for (int c = 0; c < 5; c++) begin
      apply_stimulus((c == 0 || c == 2), 1'b1);
      check_output("f2_hold_valid", value_valid, 1);
      check_output("f2_hold_value", value, 4);
    end
    check_output("f2_drop_set", drop, 1);
    pop_check("f2_value");
    value_ready = 1'b1;
    apply_stimulus(1'b0, 1'b0);
    check_output("f2_handshake_valid", value_valid, 0);
    check_output("f2_drop_sticky", drop, 1);
    clear = 1'b1;
    apply_stimulus(1'b0, 1'b0);
    clear = 1'b0;
    check_output("clear_drop", drop, 0);

    $display("[TB] frames 3/4: all ones then all zeros");
    send_frame(8'hFF, 0);
    pop_check("f3_value");
    apply_stimulus(1'b0, 1'b0);
    send_frame(8'h00, 0);
    pop_check("f4_value");
    apply_stimulus(1'b0, 1'b0);
    check_output("f4_no_drop", drop, 0);

    $display("[TB] clear mid-frame");
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b1);
    clear = 1'b1;
    apply_stimulus(1'b1, 1'b1);
    clear = 1'b0;
    check_output("clear_mid_valid", value_valid, 0);
    check_output("clear_mid_drop", drop, 0);
`ifdef UNARY_DECODER_BOUNDS_EN
    check_output("clear_lower", lower_bound, 0);
    check_output("clear_upper", upper_bound, W);
`endif
    send_frame(8'hFF, 0);
    pop_check("after_clear_value");
    apply_stimulus(1'b1, 1'b1);
    check_output("handshake_cycle_drop", drop, 1);
    check_output("handshake_cycle_valid", value_valid, 0);

    $display("[TB] async reset mid-frame");
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_output("async_reset_value", value, 0);
    check_output("async_reset_valid", value_valid, 0);
    check_output("async_reset_drop", drop, 0);
    valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    $display("[TB] frame after reset with bound tracking");
    apply_stimulus(1'b1, 1'b1);
    apply_stimulus(1'b1, 1'b1);
    apply_stimulus(1'b1, 1'b0);
`ifdef UNARY_DECODER_BOUNDS_EN
    check_output("mid_lower", lower_bound, 2);
    check_output("mid_upper", upper_bound, 7);
`endif
    check_output("mid_no_valid", value_valid, 0);
    apply_stimulus(1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b1);
    apply_stimulus(1'b1, 1'b0);
    exp_q.push_back(3);
    value_ready = 1'b0;
    apply_stimulus(1'b1, 1'b0);
    check_output("f6_valid", value_valid, 1);
`ifdef UNARY_DECODER_BOUNDS_EN
    check_output("done_lower", lower_bound, 3);
    check_output("done_upper", upper_bound, 3);
`endif
    pop_check("f6_value");
    value_ready = 1'b1;
    apply_stimulus(1'b0, 1'b0);
    check_output("f6_handshake_valid", value_valid, 0);
    check_output("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
